// File: rtl/dmem_responder.sv
// Word-organised data RAM behind valid/ready request and response channels, with a
// fixed, parameterised access latency and a single outstanding transaction.
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [29:0] DEPTH_W   = 30'(DEPTH);
    localparam logic [3:0]  WAIT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH];

    logic [29:0]   word_idx;
    logic [AW-1:0] mem_idx;
    logic          addr_err;
    logic          accept;

    assign word_idx = req_addr[31:2];
    assign mem_idx  = word_idx[AW-1:0];
    assign addr_err = (req_addr[1:0] != 2'b00) || (word_idx >= DEPTH_W);
    // A request arriving while reset is asserted is dropped, not committed.
    assign accept   = req_valid && req_ready && !rst;

    // NOTE: the RAM array has no reset branch; clearing it would turn the block RAM
    // into a huge register file, and its contents must survive rst anyway.
    always_ff @(posedge clk) begin
        if (accept && req_we && !addr_err) begin
            for (int b = 0; b < 4; b++) begin
                if (req_be[b]) begin
                    mem[mem_idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    // Load data and error flag are captured at the accept edge and held until the
    // response handshake; the read sees the pre-edge RAM, which already holds
    // every earlier store.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            rdata_q <= (req_we || addr_err) ? 32'd0 : mem[mem_idx];
            err_q   <= addr_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Response fields read as zero whenever no response is being presented.
    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;
    assign rsp_err   = rsp_valid && err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: one responder at LATENCY=1 (DEPTH=1024) and a second at
// LATENCY=0 (DEPTH=16) for the back-to-back throughput scenario.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        z_req_valid = 1'b0, z_req_we = 1'b0, z_rsp_ready = 1'b1;
    logic [31:0] z_req_addr = '0, z_req_wdata = '0;
    logic [3:0]  z_req_be = '0;
    logic        z_req_ready, z_rsp_valid, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(1024), .LATENCY(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH(16), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_be(z_req_be), .req_wdata(z_req_wdata),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    // Drives one transaction on the LATENCY=1 instance from idle through the
    // response handshake. lat = cycles from accept to rsp_valid, -1 on timeout.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wdata, output logic [31:0] rdata,
                       output logic err, output int lat, output logic post_idle);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0; req_wdata = '0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!rsp_valid) lat = -1;
        rdata = rsp_rdata;
        err   = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        post_idle = !rsp_valid && req_ready && (rsp_rdata == 32'd0) && !rsp_err;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL reset_hs got ready=%b valid=%b want ready=1 valid=0", req_ready, rsp_valid);
        end
        total++;
        if (rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
            bad++; $display("FAIL reset_data got rdata=%h err=%b want 0/0", rsp_rdata, rsp_err);
        end
        total++;
        if (z_req_ready !== 1'b1 || z_rsp_valid !== 1'b0) begin
            bad++; $display("FAIL reset_lat0 got ready=%b valid=%b want 1/0", z_req_ready, z_rsp_valid);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er, pi; int lat;
        txn(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd, er, lat, pi);
        total++;
        if (lat !== 2) begin
            bad++; $display("FAIL store_latency got=%0d want=2", lat);
        end
        total++;
        if (rd !== 32'd0 || er !== 1'b0) begin
            bad++; $display("FAIL store_rsp got rdata=%h err=%b want 0/0", rd, er);
        end
        total++;
        if (pi !== 1'b1) begin
            bad++; $display("FAIL store_post_idle got=%b want=1", pi);
        end
        txn(1'b0, 32'h10, 4'h0, 32'h0, rd, er, lat, pi);
        total++;
        if (lat !== 2) begin
            bad++; $display("FAIL load_latency got=%0d want=2", lat);
        end
        total++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            bad++; $display("FAIL load_data got rdata=%h err=%b want deadbeef/0", rd, er);
        end
    endtask

    task automatic test_byte_enable();
        logic [31:0] rd; logic er, pi; int lat;
        txn(1'b1, 32'h10, 4'b0101, 32'h11223344, rd, er, lat, pi);
        txn(1'b0, 32'h10, 4'h0, 32'h0, rd, er, lat, pi);
        total++;
        if (rd !== 32'hDE22BE44) begin
            bad++; $display("FAIL partial_store got=%h want=de22be44", rd);
        end
        txn(1'b1, 32'h10, 4'b0000, 32'h55667788, rd, er, lat, pi);
        total++;
        if (er !== 1'b0 || lat !== 2) begin
            bad++; $display("FAIL be0_rsp got err=%b lat=%0d want 0/2", er, lat);
        end
        txn(1'b0, 32'h10, 4'h0, 32'h0, rd, er, lat, pi);
        total++;
        if (rd !== 32'hDE22BE44) begin
            bad++; $display("FAIL be0_noop got=%h want=de22be44", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er, pi; int lat;
        txn(1'b0, 32'h12, 4'h0, 32'h0, rd, er, lat, pi);
        total++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            bad++; $display("FAIL misaligned_load got err=%b rdata=%h want 1/0", er, rd);
        end
        txn(1'b0, 32'h1000, 4'h0, 32'h0, rd, er, lat, pi);
        total++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            bad++; $display("FAIL oor_load got err=%b rdata=%h want 1/0", er, rd);
        end
        txn(1'b0, 32'hFFC, 4'h0, 32'h0, rd, er, lat, pi);
        total++;
        if (er !== 1'b0) begin
            bad++; $display("FAIL last_word_err got=%b want=0", er);
        end
        // Both of these would land on word 0x10 if the error gating were missing.
        txn(1'b1, 32'h11, 4'hF, 32'h00000000, rd, er, lat, pi);
        total++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            bad++; $display("FAIL misaligned_store got err=%b rdata=%h want 1/0", er, rd);
        end
        txn(1'b1, 32'h1010, 4'hF, 32'h00000000, rd, er, lat, pi);
        total++;
        if (er !== 1'b1) begin
            bad++; $display("FAIL oor_store got err=%b want 1", er);
        end
        txn(1'b0, 32'h10, 4'h0, 32'h0, rd, er, lat, pi);
        total++;
        if (rd !== 32'hDE22BE44 || er !== 1'b0) begin
            bad++; $display("FAIL err_no_write got rdata=%h err=%b want de22be44/0", rd, er);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er, pi; int lat; int waited;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'hF;
        @(posedge clk); #1;
        // Keep a clobbering store request up through the whole RESP phase.
        req_we = 1'b1; req_wdata = 32'h0;
        waited = 0;
        while (!rsp_valid && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        total++;
        if (rsp_valid !== 1'b1) begin
            bad++; $display("FAIL bp_timeout got valid=%b want 1", rsp_valid);
        end
        for (int k = 0; k < 5; k++) begin
            total++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDE22BE44 || rsp_err !== 1'b0 ||
                req_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold cycle=%0d got valid=%b rdata=%h err=%b ready=%b want 1/de22be44/0/0",
                         k, rsp_valid, rsp_rdata, rsp_err, req_ready);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL bp_release got ready=%b valid=%b want 1/0", req_ready, rsp_valid);
        end
        txn(1'b0, 32'h10, 4'h0, 32'h0, rd, er, lat, pi);
        total++;
        if (rd !== 32'hDE22BE44) begin
            bad++; $display("FAIL bp_no_accept got=%h want=de22be44", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        vals[0] = 32'h01234567; vals[1] = 32'h89ABCDEF;
        vals[2] = 32'hFFFF0000; vals[3] = 32'h0F0FF0F0;
        z_rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            z_req_valid = 1'b1; z_req_we = 1'b1; z_req_be = 4'hF;
            z_req_addr = 32'(4 * i); z_req_wdata = vals[i];
            @(posedge clk); #1;
            z_req_valid = 1'b0; z_req_we = 1'b0;
            total++;
            if (z_rsp_valid !== 1'b1 || z_rsp_err !== 1'b0) begin
                bad++; $display("FAIL b2b_store%0d got valid=%b err=%b want 1/0", i, z_rsp_valid, z_rsp_err);
            end
            @(posedge clk); #1;
        end
        z_req_valid = 1'b1; z_req_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (z_req_ready !== 1'b1 || z_rsp_valid !== 1'b0) begin
                bad++; $display("FAIL b2b_idle%0d got ready=%b valid=%b want 1/0", i, z_req_ready, z_rsp_valid);
            end
            z_req_addr = 32'(4 * i);
            @(posedge clk); #1;
            total++;
            if (z_rsp_valid !== 1'b1 || z_req_ready !== 1'b0 || z_rsp_rdata !== vals[i]) begin
                bad++;
                $display("FAIL b2b_load%0d got valid=%b ready=%b rdata=%h want 1/0/%h",
                         i, z_rsp_valid, z_req_ready, z_rsp_rdata, vals[i]);
            end
            @(posedge clk); #1;
        end
        z_req_addr = 32'h40;
        @(posedge clk); #1;
        z_req_valid = 1'b0;
        total++;
        if (z_rsp_valid !== 1'b1 || z_rsp_err !== 1'b1 || z_rsp_rdata !== 32'd0) begin
            bad++; $display("FAIL b2b_oor got valid=%b err=%b rdata=%h want 1/1/0", z_rsp_valid, z_rsp_err, z_rsp_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er, pi; int lat;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_be = 4'hF; req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL midreset got valid=%b ready=%b want 0/1", rsp_valid, req_ready);
        end
        txn(1'b0, 32'h20, 4'h0, 32'h0, rd, er, lat, pi);
        total++;
        if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
            bad++; $display("FAIL midreset_store got rdata=%h err=%b want cafef00d/0", rd, er);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_enable();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
